// File: rtl/vm_pkg.sv
// Shared types and constants for the vend sequencer: FSM states, coin values,
// hopper select encodings, fault codes and the greedy coin choice.
package vm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOTOR,
    S_SETTLE,
    S_CHG_SEL,
    S_CHG_WAIT,
    S_DONE,
    S_FAULT
  } vm_state_t;

  localparam logic [15:0] COIN_10 = 16'd10;
  localparam logic [15:0] COIN_5  = 16'd5;
  localparam logic [15:0] COIN_1  = 16'd1;

  localparam logic [1:0] SEL_10 = 2'd0;
  localparam logic [1:0] SEL_5  = 2'd1;
  localparam logic [1:0] SEL_1  = 2'd2;

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_MOTOR = 2'd1;
  localparam logic [1:0] FC_HOP   = 2'd2;

  // Largest coin not exceeding the remaining amount.
  function automatic logic [1:0] greedy_sel(input logic [15:0] rem);
    if (rem >= COIN_10)     greedy_sel = SEL_10;
    else if (rem >= COIN_5) greedy_sel = SEL_5;
    else                    greedy_sel = SEL_1;
  endfunction

  function automatic logic [15:0] coin_value(input logic [1:0] sel);
    case (sel)
      SEL_10:  coin_value = COIN_10;
      SEL_5:   coin_value = COIN_5;
      default: coin_value = COIN_1;
    endcase
  endfunction

endpackage

// File: rtl/vm_timeout_ctr.sv
// Loadable up-counter with clear; expired flags the cycle in which the
// count completes `limit` cycles (count == limit-1 or beyond).
module vm_timeout_ctr #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             expired
);

  always_ff @(posedge clock) begin
    if (reset)      count <= '0;
    else if (clear) count <= '0;
    else if (load)  count <= load_val;
    else if (inc)   count <= count + WIDTH'(1);
  end

  assign expired = (count + WIDTH'(1)) >= limit;

endmodule

// File: rtl/vm_vend_sequencer.sv
// Sequences motor dispense, drop settle and greedy coin payout through a
// single req/ack hopper; one shared timeout counter serves all timed states.
module vm_vend_sequencer
  import vm_pkg::*;
#(
  parameter int unsigned MOTOR_TIMEOUT = 255,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned HOP_TIMEOUT   = 127
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vend_req,
  input  logic        refund_only,
  input  logic [1:0]  vend_slot,
  input  logic [15:0] change_amt,
  output logic        vend_busy,
  output logic        motor_en,
  output logic [1:0]  motor_slot,
  input  logic        drop_sensor,
  output logic        hop_req,
  output logic [1:0]  hop_sel,
  input  logic        hop_ack,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [15:0] paid_total
);

  vm_state_t   state_q, state_d;
  logic [1:0]  slot_q;
  logic [15:0] remaining_q;
  logic [1:0]  hop_sel_q;
  logic [15:0] paid_q;
  logic [1:0]  fault_code_q;

  logic        tmr_clr, tmr_inc, tmr_expired;
  logic [15:0] tmr_limit, tmr_count;

  vm_timeout_ctr #(.WIDTH(16)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (tmr_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (tmr_inc),
    .limit    (tmr_limit),
    .count    (tmr_count),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Completion events (drop, ack) take priority over the timer expiring.
  always_comb begin
    state_d   = state_q;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    tmr_limit = 16'(HOP_TIMEOUT);
    case (state_q)
      S_IDLE: begin
        tmr_clr = 1'b1;
        if (vend_req) state_d = refund_only ? S_CHG_SEL : S_MOTOR;
      end
      S_MOTOR: begin
        tmr_limit = 16'(MOTOR_TIMEOUT);
        if (drop_sensor) begin
          state_d = S_SETTLE;
          tmr_clr = 1'b1;
        end else if (tmr_expired) begin
          state_d = S_FAULT;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      S_SETTLE: begin
        tmr_limit = 16'(SETTLE_CYCLES);
        if (tmr_expired) state_d = S_CHG_SEL;
        else             tmr_inc = 1'b1;
      end
      S_CHG_SEL: begin
        tmr_clr = 1'b1;
        state_d = (remaining_q == '0) ? S_DONE : S_CHG_WAIT;
      end
      S_CHG_WAIT: begin
        if (hop_ack)          state_d = S_CHG_SEL;
        else if (tmr_expired) state_d = S_FAULT;
        else                  tmr_inc = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q       <= '0;
      remaining_q  <= '0;
      hop_sel_q    <= '0;
      paid_q       <= '0;
      fault_code_q <= FC_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (vend_req) begin
            slot_q      <= vend_slot;
            remaining_q <= change_amt;
            paid_q      <= '0;
          end
        end
        S_MOTOR: begin
          if (!drop_sensor && tmr_expired) fault_code_q <= FC_MOTOR;
        end
        S_CHG_SEL: begin
          if (remaining_q != '0) hop_sel_q <= greedy_sel(remaining_q);
        end
        S_CHG_WAIT: begin
          if (hop_ack) begin
            remaining_q <= remaining_q - coin_value(hop_sel_q);
            paid_q      <= paid_q + coin_value(hop_sel_q);
          end else if (tmr_expired) begin
            fault_code_q <= FC_HOP;
          end
        end
        default: ;
      endcase
    end
  end

  assign vend_busy  = (state_q != S_IDLE);
  assign motor_en   = (state_q == S_MOTOR);
  assign motor_slot = slot_q;
  assign hop_req    = (state_q == S_CHG_WAIT);
  assign hop_sel    = hop_sel_q;
  assign done       = (state_q == S_DONE);
  assign fault      = (state_q == S_FAULT);
  assign fault_code = fault_code_q;
  assign paid_total = paid_q;

endmodule

// File: tb/tb_vm_vend_sequencer.sv
// Directed bench: table of refund payouts plus hand-written motor, timeout,
// reset and busy sequences.
module tb_vm_vend_sequencer;

  localparam int unsigned T_MOTOR  = 8;
  localparam int unsigned T_SETTLE = 4;
  localparam int unsigned T_HOP    = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        vend_req = 1'b0;
  logic        refund_only = 1'b0;
  logic [1:0]  vend_slot = '0;
  logic [15:0] change_amt = '0;
  logic        vend_busy;
  logic        motor_en;
  logic [1:0]  motor_slot;
  logic        drop_sensor = 1'b0;
  logic        hop_req;
  logic [1:0]  hop_sel;
  logic        hop_ack = 1'b0;
  logic        done;
  logic        fault;
  logic [1:0]  fault_code;
  logic [15:0] paid_total;

  int checks = 0;
  int errors = 0;

  vm_vend_sequencer #(
    .MOTOR_TIMEOUT (T_MOTOR),
    .SETTLE_CYCLES (T_SETTLE),
    .HOP_TIMEOUT   (T_HOP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .vend_req    (vend_req),
    .refund_only (refund_only),
    .vend_slot   (vend_slot),
    .change_amt  (change_amt),
    .vend_busy   (vend_busy),
    .motor_en    (motor_en),
    .motor_slot  (motor_slot),
    .drop_sensor (drop_sensor),
    .hop_req     (hop_req),
    .hop_sel     (hop_sel),
    .hop_ack     (hop_ack),
    .done        (done),
    .fault       (fault),
    .fault_code  (fault_code),
    .paid_total  (paid_total)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] amt;
    int          n10;
    int          n5;
    int          n1;
  } vec_t;

  vec_t tbl [9];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic start_vend(input logic refund, input logic [1:0] slot, input logic [15:0] amt);
    vend_req    = 1'b1;
    refund_only = refund;
    vend_slot   = slot;
    change_amt  = amt;
    tick();
    vend_req    = 1'b0;
    refund_only = 1'b0;
  endtask

  // Acts as the hopper: acks each request ack_delay cycles after it appears,
  // for the first ack_limit coins only; stops on done or fault.
  task automatic serve_coins(input int ack_delay, input int ack_limit, input int max_cycles,
                             output int n10, output int n5, output int n1,
                             output int last_wait, output bit got_done,
                             output bit got_fault, output bit mono_ok);
    int  wait_cnt;
    int  coins;
    int  last_sel;
    bit  prev;
    n10 = 0; n5 = 0; n1 = 0; last_wait = 0;
    got_done = 0; got_fault = 0; mono_ok = 1;
    wait_cnt = 0; coins = 0; last_sel = 0; prev = 0;
    for (int c = 0; c < max_cycles; c++) begin
      tick();
      hop_ack = 1'b0;
      if (done)  begin got_done = 1; break; end
      if (fault) begin got_fault = 1; break; end
      if (hop_req) begin
        if (!prev) begin
          coins++;
          wait_cnt = 0;
          case (hop_sel)
            2'd0:    n10++;
            2'd1:    n5++;
            2'd2:    n1++;
            default: mono_ok = 0;
          endcase
          if (int'(hop_sel) < last_sel) mono_ok = 0;
          last_sel = int'(hop_sel);
        end
        wait_cnt++;
        last_wait = wait_cnt;
        if (wait_cnt == ack_delay && coins <= ack_limit) hop_ack = 1'b1;
      end
      prev = hop_req;
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {5'd0, vend_busy, motor_en, motor_slot, hop_req, hop_sel, done,
            fault, fault_code, paid_total};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n10, n5, n1, lw, nmot, extra;
    bit gd, gf, mono;

    tbl[0] = '{16'd0,   0,  0, 0};
    tbl[1] = '{16'd1,   0,  0, 1};
    tbl[2] = '{16'd4,   0,  0, 4};
    tbl[3] = '{16'd5,   0,  1, 0};
    tbl[4] = '{16'd9,   0,  1, 4};
    tbl[5] = '{16'd10,  1,  0, 0};
    tbl[6] = '{16'd17,  1,  1, 2};
    tbl[7] = '{16'd29,  2,  1, 4};
    tbl[8] = '{16'd100, 10, 0, 0};

    reset = 1'b1;
    tick();
    tick();
    check("reset_outs", all_outs(), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_busy", {31'd0, vend_busy}, 32'd0);

    // Refund of zero: done two edges after the request edge, no mechanics.
    start_vend(1'b1, 2'd1, 16'd0);
    check("r0_done_early", {31'd0, done}, 32'd0);
    check("r0_busy", {31'd0, vend_busy}, 32'd1);
    check("r0_motor", {31'd0, motor_en}, 32'd0);
    tick();
    check("r0_done", {31'd0, done}, 32'd1);
    check("r0_hopreq", {31'd0, hop_req}, 32'd0);
    tick();
    check("r0_done_off", {31'd0, done}, 32'd0);
    check("r0_idle", {31'd0, vend_busy}, 32'd0);

    // Table of refund-only payouts.
    for (int i = 0; i < 9; i++) begin
      start_vend(1'b1, 2'(i % 4), tbl[i].amt);
      serve_coins(1 + i % 3, 1000, 300, n10, n5, n1, lw, gd, gf, mono);
      check($sformatf("tbl%0d_done", i), {31'd0, gd}, 32'd1);
      check($sformatf("tbl%0d_n10", i), n10, tbl[i].n10);
      check($sformatf("tbl%0d_n5", i), n5, tbl[i].n5);
      check($sformatf("tbl%0d_n1", i), n1, tbl[i].n1);
      check($sformatf("tbl%0d_paid", i), {16'd0, paid_total}, {16'd0, tbl[i].amt});
      check($sformatf("tbl%0d_order", i), {31'd0, mono}, 32'd1);
      tick();
      check($sformatf("tbl%0d_idle", i), {31'd0, vend_busy}, 32'd0);
    end

    // Normal vend with a rejected second request while the motor runs.
    start_vend(1'b0, 2'd2, 16'd17);
    check("nv_motor", {31'd0, motor_en}, 32'd1);
    check("nv_slot", {30'd0, motor_slot}, 32'd2);
    vend_req = 1'b1; vend_slot = 2'd1; refund_only = 1'b1; change_amt = 16'd99;
    tick();
    vend_req = 1'b0; refund_only = 1'b0;
    check("busy_slot", {30'd0, motor_slot}, 32'd2);
    check("busy_motor", {31'd0, motor_en}, 32'd1);
    tick();
    tick();
    tick();
    drop_sensor = 1'b1;
    tick();
    drop_sensor = 1'b0;
    check("nv_motor_off", {31'd0, motor_en}, 32'd0);
    check("nv_settle_busy", {31'd0, vend_busy}, 32'd1);
    serve_coins(2, 1000, 200, n10, n5, n1, lw, gd, gf, mono);
    check("nv_done", {31'd0, gd}, 32'd1);
    check("nv_coins", n10 * 100 + n5 * 10 + n1, 32'd112);
    check("nv_order", {31'd0, mono}, 32'd1);
    check("nv_paid", {16'd0, paid_total}, 32'd17);
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) extra++;
    end
    check("nv_one_done", extra, 32'd0);
    check("nv_idle", {31'd0, vend_busy}, 32'd0);

    // Motor timeout: drop sensor never arrives.
    start_vend(1'b0, 2'd1, 16'd5);
    nmot = 0;
    while (motor_en && nmot < 50) begin
      nmot++;
      tick();
    end
    check("mt_cycles", nmot, T_MOTOR);
    check("mt_fault", {31'd0, fault}, 32'd1);
    check("mt_code", {30'd0, fault_code}, 32'd1);
    vend_req = 1'b1; drop_sensor = 1'b1; hop_ack = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    vend_req = 1'b0; drop_sensor = 1'b0; hop_ack = 1'b0;
    check("mt_hold_fault", {31'd0, fault}, 32'd1);
    check("mt_hold_code", {30'd0, fault_code}, 32'd1);
    check("mt_hold_motor", {31'd0, motor_en}, 32'd0);
    check("mt_hold_busy", {31'd0, vend_busy}, 32'd1);
    check("mt_paid", {16'd0, paid_total}, 32'd0);
    reset = 1'b1;
    tick();
    check("mt_reset_outs", all_outs(), 32'd0);
    reset = 1'b0;
    tick();

    // Hopper timeout on the third coin.
    start_vend(1'b1, 2'd0, 16'd25);
    serve_coins(1, 2, 200, n10, n5, n1, lw, gd, gf, mono);
    check("ht_fault_seen", {31'd0, gf}, 32'd1);
    check("ht_n10", n10, 32'd2);
    check("ht_n5", n5, 32'd1);
    check("ht_req_cycles", lw, T_HOP);
    check("ht_paid", {16'd0, paid_total}, 32'd20);
    check("ht_code", {30'd0, fault_code}, 32'd2);
    check("ht_hopreq", {31'd0, hop_req}, 32'd0);
    tick();
    tick();
    check("ht_paid_frozen", {16'd0, paid_total}, 32'd20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Reset during the second CHG_WAIT, then a fresh vend.
    start_vend(1'b1, 2'd3, 16'd30);
    tick();
    check("rm_req1", {31'd0, hop_req}, 32'd1);
    hop_ack = 1'b1;
    tick();
    hop_ack = 1'b0;
    tick();
    check("rm_req2", {31'd0, hop_req}, 32'd1);
    check("rm_paid_mid", {16'd0, paid_total}, 32'd10);
    reset = 1'b1;
    tick();
    check("rm_reset_outs", all_outs(), 32'd0);
    reset = 1'b0;
    tick();
    check("rm_idle", all_outs(), 32'd0);
    start_vend(1'b0, 2'd3, 16'd6);
    check("fr_slot", {30'd0, motor_slot}, 32'd3);
    tick();
    drop_sensor = 1'b1;
    tick();
    drop_sensor = 1'b0;
    serve_coins(1, 1000, 200, n10, n5, n1, lw, gd, gf, mono);
    check("fr_done", {31'd0, gd}, 32'd1);
    check("fr_coins", n10 * 100 + n5 * 10 + n1, 32'd11);
    check("fr_paid", {16'd0, paid_total}, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vm_vend_sequencer.md
Name: vm_vend_sequencer

Overview:
Controller that sequences the shared vend mechanics once the pricing logic has decided a sale or a refund. It drives the dispense motor for one drink slot and waits for the drop sensor. It then pays out the change amount coin by coin through a single coin hopper, using a req/ack handshake. It sits between the vending FSM (which supplies slot, refund flag and change value) and the physical motor and hopper interfaces.

Parameters:
MOTOR_TIMEOUT, 255, max cycles motor_en may stay high without drop_sensor before fault
SETTLE_CYCLES, 4, cycles waited after drop_sensor before change payout starts
HOP_TIMEOUT, 127, max cycles hop_req may stay high without hop_ack before fault

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
vend_req  input  1  one-cycle request; sampled only in IDLE
refund_only  input  1  with vend_req: skip motor, pay change only
vend_slot  input  2  drink slot index 0..3
change_amt  input  16  change to pay, in money units
vend_busy  output  1  high in every state except IDLE
motor_en  output  1  dispense motor drive
motor_slot  output  2  latched slot, valid while motor_en
drop_sensor  input  1  drink-dropped indication
hop_req  output  1  coin payout request, level
hop_sel  output  2  coin select: 0=10, 1=5, 2=1, 3 unused
hop_ack  input  1  hopper has ejected the requested coin
done  output  1  one-cycle pulse on successful completion
fault  output  1  sticky fault flag
fault_code  output  2  0=none, 1=motor timeout, 2=hopper timeout
paid_total  output  16  running total of change paid for the current vend

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs are 0: vend_busy, motor_en, motor_slot, hop_req, hop_sel, done, fault, fault_code, paid_total. Internal remaining and timer are cleared. Reset has priority in every state, mid-motor and mid-payout. Outputs drop at the same edge.
- States: IDLE, MOTOR, SETTLE, CHG_SEL, CHG_WAIT, DONE, FAULT.
- IDLE:
  - On vend_req=1, latch vend_slot, change_amt (as remaining) and refund_only.
  - Clear paid_total and timer.
  - Next state is CHG_SEL if refund_only, else MOTOR.
- MOTOR:
  - motor_en=1 and motor_slot=latched slot. Timer increments each cycle.
  - drop_sensor=1 -> SETTLE, with motor_en 0 from the next cycle.
  - Timer reaching MOTOR_TIMEOUT without the sensor -> FAULT with code 1.
  - If drop_sensor=1 and the timer reaches MOTOR_TIMEOUT in the same cycle, the sensor wins.
- SETTLE: wait SETTLE_CYCLES cycles, then go to CHG_SEL.
- CHG_SEL (one cycle):
  - remaining==0 -> DONE.
  - Otherwise pick the greedy coin: 10 if remaining>=10, else 5 if remaining>=5, else 1.
  - Drive hop_sel, set hop_req=1, clear timer, go to CHG_WAIT.
- CHG_WAIT:
  - hop_req stays 1 and hop_sel stays stable.
  - On hop_ack=1: remaining -= coin and paid_total += coin; hop_req is 0 next cycle; go to CHG_SEL.
  - Timer reaching HOP_TIMEOUT -> FAULT with code 2. hop_ack in the same cycle as timeout wins.
- DONE: done=1 for exactly one cycle, then IDLE.
- FAULT: motor_en=0, hop_req=0, fault=1, fault_code held, paid_total frozen, vend_busy=1. Exit only via reset.
- Ignored inputs:
  - vend_req outside IDLE.
  - drop_sensor outside MOTOR.
  - hop_ack outside CHG_WAIT.
- Latencies:
  - Refund of 0: vend_req at edge N, done high in cycle N+2.
  - Each coin costs 1 CHG_SEL cycle, plus CHG_WAIT until ack (at least 1 cycle).
- Arithmetic is 16-bit unsigned; remaining never underflows because the greedy choice is always <= remaining.

Decomposition:
- Package vm_pkg holds:
  - the state enum;
  - coin constants COIN_10=10, COIN_5=5, COIN_1=1;
  - hop_sel encodings;
  - fault code constants.
- One natural sub-module, vm_timeout_ctr: a loadable up-counter with clear and an "expired" compare against a runtime limit. It is instantiated once and shared between MOTOR and CHG_WAIT by loading the respective limit.

Test Plan:
- Normal vend: slot=2, change_amt=17, drop_sensor after 5 motor cycles, hop_ack 2 cycles after each hop_req -> motor_slot=2; coins hop_sel 0,1,2,2; paid_total=17; done pulse; vend_busy low after.
- Refund only, change 0: refund_only=1, change_amt=0 -> no motor_en, no hop_req, done high 2 cycles after the vend_req edge.
- Motor timeout: MOTOR_TIMEOUT=8, drop_sensor never asserts -> motor_en high 8 cycles, then fault=1, fault_code=1, motor_en=0, held until reset.
- Hopper timeout: change_amt=25, ack first two coins, withhold the third -> paid_total=20, fault_code=2, hop_req=0 after HOP_TIMEOUT.
- Reset mid-payout: change_amt=30, reset during the second CHG_WAIT -> next cycle all outputs 0, state IDLE; a fresh vend then completes normally.
- Busy rejection: second vend_req during MOTOR with a different slot -> ignored; motor_slot keeps the original; exactly one done pulse.
